seq_restoring_divider: RTL and testbench

//   Iterative unsigned restoring divider, the inverse datapath of the 4x4 exact

---
 rtl/seq_restoring_divider.sv | 78 +++++++
 tb/tb_seq_restoring_divider.sv | 127 ++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative unsigned restoring divider, one quotient bit per clock, valid/ready in and out
module seq_restoring_divider #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_zero
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [M-1:0]  div_q, div_d;
  logic [M-1:0]  p_q, p_d;
  logic          dz_q, dz_d;
  logic [M:0]    p_sh;
  logic          ge;
  // Dividend bits leave at the top of sr while quotient bits enter at the bottom,
  // so after N steps sr holds the quotient. P stays below the divisor, so M bits suffice.
  assign p_sh = {p_q, sr_q[N-1]};
  assign ge   = p_sh >= {1'b0, div_q};
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign quotient  = out_valid ? sr_q : '0;
  assign remainder = out_valid ? p_q : '0;
  assign div_zero  = dz_q;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sr_d    = sr_q;
    div_d   = div_q;
    p_d     = p_q;
    dz_d    = dz_q;
    if (state_q == IDLE && in_valid) begin
      div_d   = divisor;
      count_d = '0;
      state_d = (divisor == '0) ? DONE : CALC;
      sr_d    = (divisor == '0) ? '1 : dividend;
      p_d     = (divisor == '0) ? dividend[M-1:0] : '0;
      dz_d    = divisor == '0;
    end else if (state_q == CALC) begin
      p_d     = ge ? M'(p_sh - {1'b0, div_q}) : p_sh[M-1:0];
      sr_d    = {sr_q[N-2:0], ge};
      count_d = count_q + CW'(1);
      state_d = (count_q == CW'(N - 1)) ? DONE : CALC;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
      dz_d    = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      sr_q    <= '0;
      div_q   <= '0;
      p_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sr_q    <= sr_d;
      div_q   <= div_d;
      p_q     <= p_d;
      dz_q    <= dz_d;
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: scoreboard bench for the restoring divider
module tb_seq_restoring_divider;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;
  int n_chk = 0;
  int n_err = 0;
  typedef struct packed {logic [7:0] q; logic [3:0] r; logic dz; logic [7:0] lat;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  seq_restoring_divider #(.N(8), .M(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int hold);
    exp_t e;
    int lat;
    e.q   = (b == 0) ? 8'hff : a / b;
    e.r   = (b == 0) ? a[3:0] : a % b;
    e.dz  = b == 0;
    e.lat = (b == 0) ? 8'd0 : 8'd8;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid_seen", out_valid, 1);
    e = sb.pop_front();
    check("latency", lat, e.lat);
    check("quotient", quotient, e.q);
    check("remainder", remainder, e.r);
    check("div_zero", div_zero, e.dz);
    check("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_quotient", quotient, e.q);
      check("hold_remainder", remainder, e.r);
      check("hold_dz", div_zero, e.dz);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("released_valid", out_valid, 0);
    check("released_in_ready", in_ready, 1);
    check("released_dz", div_zero, 0);
  endtask
  initial begin
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_zero", div_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    run_op(8'd143, 4'd7, 0);
    run_op(8'd255, 4'd1, 0);
    run_op(8'd5, 4'd9, 0);
    run_op(8'd255, 4'd15, 0);
    run_op(8'd200, 4'd0, 0);
    run_op(8'd143, 4'd7, 3);
    run_op(8'd77, 4'd0, 3);
    for (int a = 1; a < 16; a++)
      for (int b = 1; b < 16; b++)
        run_op(8'(a * b), 4'(b), 0);
    for (int i = 0; i < 30; i++)
      run_op(8'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
    @(negedge clk);
    dividend = 8'd250;
    divisor  = 4'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      check("midrst_no_output", out_valid, 0);
    end
    run_op(8'd100, 4'd10, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
